// File: rtl/alu_pkg.sv
// Shared ALU package: command encoding, register-address constants and the
// bookkeeping struct carried alongside the ALU operands.
package alu_pkg;

  typedef logic [2:0] alu_cmd_t;

  localparam alu_cmd_t ADD  = 3'b000;
  localparam alu_cmd_t SUB  = 3'b001;
  localparam alu_cmd_t XOR  = 3'b010;
  localparam alu_cmd_t SLT  = 3'b011;
  localparam alu_cmd_t AND  = 3'b100;
  localparam alu_cmd_t NAND = 3'b101;
  localparam alu_cmd_t NOR  = 3'b110;
  localparam alu_cmd_t OR   = 3'b111;

  localparam int REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] dest;
    logic                  reg_write;
    logic                  mem_read;
  } ex_meta_t;

endpackage

// File: rtl/alu_issue_stage_if.sv
// Decode-to-ALU issue bus: decoded instruction, forwarding candidates and
// the registered operands/bookkeeping presented to the ALU.
interface alu_issue_stage_if
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
);
  logic                  in_valid;
  alu_cmd_t              in_command;
  logic [REG_ADDR_W-1:0] in_rs_addr;
  logic [REG_ADDR_W-1:0] in_rt_addr;
  logic [WIDTH-1:0]      in_rs_data;
  logic [WIDTH-1:0]      in_rt_data;
  logic [15:0]           in_imm;
  logic                  in_use_imm;
  logic [REG_ADDR_W-1:0] in_dest;
  logic                  in_reg_write;
  logic                  in_mem_read;
  logic [WIDTH-1:0]      alu_result;
  logic                  mem_fwd_we;
  logic [REG_ADDR_W-1:0] mem_fwd_addr;
  logic [WIDTH-1:0]      mem_fwd_data;
  logic                  flush;
  logic                  stall_in;
  logic                  stall_out;
  logic [WIDTH-1:0]      operandA;
  logic [WIDTH-1:0]      operandB;
  alu_cmd_t              command;
  logic                  ex_valid;
  logic [REG_ADDR_W-1:0] ex_dest;
  logic                  ex_reg_write;
  logic                  ex_mem_read;

  modport master (
    output in_valid, in_command, in_rs_addr, in_rt_addr, in_rs_data, in_rt_data,
           in_imm, in_use_imm, in_dest, in_reg_write, in_mem_read, alu_result,
           mem_fwd_we, mem_fwd_addr, mem_fwd_data, flush, stall_in,
    input  stall_out, operandA, operandB, command, ex_valid, ex_dest,
           ex_reg_write, ex_mem_read
  );

  modport slave (
    input  in_valid, in_command, in_rs_addr, in_rt_addr, in_rs_data, in_rt_data,
           in_imm, in_use_imm, in_dest, in_reg_write, in_mem_read, alu_result,
           mem_fwd_we, mem_fwd_addr, mem_fwd_data, flush, stall_in,
    output stall_out, operandA, operandB, command, ex_valid, ex_dest,
           ex_reg_write, ex_mem_read
  );
endinterface

// File: rtl/alu_issue_stage_fwd_mux.sv
// Operand bypass select: EX result beats MEM writeback beats register file.
// Combinational, zero latency; no backpressure. $0 always takes rf_data.
module fwd_mux
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [REG_ADDR_W-1:0] addr,
  input  logic [WIDTH-1:0]      rf_data,
  input  logic                  ex_en,
  input  logic [REG_ADDR_W-1:0] ex_addr,
  input  logic [WIDTH-1:0]      ex_data,
  input  logic                  mem_en,
  input  logic [REG_ADDR_W-1:0] mem_addr,
  input  logic [WIDTH-1:0]      mem_data,
  output logic [WIDTH-1:0]      sel_data
);

  always_comb begin
    sel_data = rf_data;
    if (addr != REG_ZERO) begin
      if (ex_en && (ex_addr == addr))
        sel_data = ex_data;
      else if (mem_en && (mem_addr == addr))
        sel_data = mem_data;
    end
  end

endmodule

// File: rtl/alu_issue_stage.sv
// ID/EX register feeding the ALU, with operand forwarding under ALU_ISSUE_FWD_EN.
// Latency: one cycle from capture to operandA/operandB/command/ex_* outputs.
// Backpressure: stall_in holds all state; stall_out requests a decode hold on a hazard.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic               clk,
  input logic               rst_n,
  alu_issue_stage_if.slave  bus
);

  logic [WIDTH-1:0] opa_q, opb_q;
  alu_cmd_t         cmd_q;
  ex_meta_t         meta_q;

  logic [WIDTH-1:0] rs_sel, rt_sel, opb_nxt, imm_ext;
  logic             ex_fwd_en, mem_fwd_en;
  logic             load_use, hazard;

`ifdef ALU_ISSUE_FWD_EN
  // A load's value is not ready in EX, so only non-load results bypass from EX.
  assign ex_fwd_en  = meta_q.valid & meta_q.reg_write & ~meta_q.mem_read;
  assign mem_fwd_en = bus.mem_fwd_we;
`else
  assign ex_fwd_en  = 1'b0;
  assign mem_fwd_en = 1'b0;
`endif

  fwd_mux #(.WIDTH(WIDTH)) u_fwd_a (
    .addr     (bus.in_rs_addr),
    .rf_data  (bus.in_rs_data),
    .ex_en    (ex_fwd_en),
    .ex_addr  (meta_q.dest),
    .ex_data  (bus.alu_result),
    .mem_en   (mem_fwd_en),
    .mem_addr (bus.mem_fwd_addr),
    .mem_data (bus.mem_fwd_data),
    .sel_data (rs_sel)
  );

  fwd_mux #(.WIDTH(WIDTH)) u_fwd_b (
    .addr     (bus.in_rt_addr),
    .rf_data  (bus.in_rt_data),
    .ex_en    (ex_fwd_en),
    .ex_addr  (meta_q.dest),
    .ex_data  (bus.alu_result),
    .mem_en   (mem_fwd_en),
    .mem_addr (bus.mem_fwd_addr),
    .mem_data (bus.mem_fwd_data),
    .sel_data (rt_sel)
  );

  assign imm_ext = {{(WIDTH-16){bus.in_imm[15]}}, bus.in_imm};
  assign opb_nxt = bus.in_use_imm ? imm_ext : rt_sel;

  assign load_use = bus.in_valid & meta_q.valid & meta_q.mem_read &
                    (meta_q.dest != REG_ZERO) &
                    ((meta_q.dest == bus.in_rs_addr) |
                     (~bus.in_use_imm & (meta_q.dest == bus.in_rt_addr)));

`ifdef ALU_ISSUE_FWD_EN
  assign hazard = load_use;
`else
  // Without bypass paths, any in-flight writer of a live source must drain first.
  logic rs_live, rt_live, ex_wr, hit_rs, hit_rt;
  assign rs_live = bus.in_rs_addr != REG_ZERO;
  assign rt_live = ~bus.in_use_imm & (bus.in_rt_addr != REG_ZERO);
  assign ex_wr   = meta_q.valid & meta_q.reg_write;
  assign hit_rs  = rs_live & ((ex_wr & (meta_q.dest == bus.in_rs_addr)) |
                              (bus.mem_fwd_we & (bus.mem_fwd_addr == bus.in_rs_addr)));
  assign hit_rt  = rt_live & ((ex_wr & (meta_q.dest == bus.in_rt_addr)) |
                              (bus.mem_fwd_we & (bus.mem_fwd_addr == bus.in_rt_addr)));
  assign hazard  = load_use | (bus.in_valid & (hit_rs | hit_rt));
`endif

  // During reset the held state is cleared, so only the downstream hold passes through.
  assign bus.stall_out = bus.stall_in | (hazard & ~bus.flush & rst_n);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opa_q  <= '0;
      opb_q  <= '0;
      cmd_q  <= ADD;
      meta_q <= '0;
    end else if (bus.flush) begin
      meta_q.valid     <= 1'b0;
      meta_q.reg_write <= 1'b0;
      meta_q.mem_read  <= 1'b0;
    end else if (bus.stall_in) begin
      meta_q <= meta_q;
    end else if (hazard || !bus.in_valid) begin
      meta_q.valid     <= 1'b0;
      meta_q.reg_write <= 1'b0;
      meta_q.mem_read  <= 1'b0;
    end else begin
      opa_q            <= rs_sel;
      opb_q            <= opb_nxt;
      cmd_q            <= bus.in_command;
      meta_q.valid     <= 1'b1;
      meta_q.dest      <= bus.in_dest;
      meta_q.reg_write <= bus.in_reg_write;
      meta_q.mem_read  <= bus.in_mem_read;
    end
  end

  assign bus.operandA     = opa_q;
  assign bus.operandB     = opb_q;
  assign bus.command      = cmd_q;
  assign bus.ex_valid     = meta_q.valid;
  assign bus.ex_dest      = meta_q.dest;
  assign bus.ex_reg_write = meta_q.reg_write;
  assign bus.ex_mem_read  = meta_q.mem_read;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: directed scenarios plus random traffic, checked by a
// queue-based scoreboard against a spec-level model (honours ALU_ISSUE_FWD_EN).
module tb_alu_issue_stage;
  import alu_pkg::*;

  typedef struct packed {
    logic        valid;
    logic [2:0]  cmd;
    logic [4:0]  rs, rt;
    logic [31:0] rs_d, rt_d;
    logic [15:0] imm;
    logic        use_imm;
    logic [4:0]  dest;
    logic        rw, mr;
    logic        mem_we;
    logic [4:0]  mem_addr;
    logic [31:0] mem_data;
    logic        flush, stall;
  } stim_t;

  typedef struct packed {
    logic        stall;
    logic [31:0] opa, opb;
    logic [2:0]  cmd;
    logic        valid;
    logic [4:0]  dest;
    logic        rw, mr;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  alu_issue_stage_if #(.WIDTH(32)) bus ();
  alu_issue_stage #(.WIDTH(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;
  exp_t sbq[$];

  // Reference state: what the stage should be holding right now.
  logic [31:0] m_opa, m_opb;
  logic [2:0]  m_cmd;
  logic        m_valid, m_rw, m_mr;
  logic [4:0]  m_dest;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] c);
    case (c)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a ^ b;
      3'd3: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd4: return a & b;
      3'd5: return ~(a & b);
      3'd6: return ~(a | b);
      default: return a | b;
    endcase
  endfunction

  // Newest producer of a register wins: the held instruction, then MEM, then the file.
  function automatic logic [31:0] src_val(input logic [4:0] addr, input logic [31:0] rf,
                                          input logic [31:0] alu_r, input stim_t s);
`ifdef ALU_ISSUE_FWD_EN
    if (addr == 5'd0) return rf;
    if (m_valid && m_rw && !m_mr && m_dest == addr) return alu_r;
    if (s.mem_we && s.mem_addr == addr) return s.mem_data;
`endif
    return rf;
  endfunction

  function automatic bit pending_writer(input logic [4:0] addr, input stim_t s);
    if (addr == 5'd0) return 1'b0;
    return (m_valid && m_rw && m_dest == addr) || (s.mem_we && s.mem_addr == addr);
  endfunction

  function automatic void model_reset();
    m_opa = '0; m_opb = '0; m_cmd = 3'd0;
    m_valid = 1'b0; m_rw = 1'b0; m_mr = 1'b0; m_dest = '0;
  endfunction

  task automatic step(input stim_t s);
    logic [31:0] alu_r;
    bit ld, haz;
    exp_t e;
    @(negedge clk);
    alu_r = alu_ref(m_opa, m_opb, m_cmd);
    bus.in_valid = s.valid;     bus.in_command = s.cmd;
    bus.in_rs_addr = s.rs;      bus.in_rt_addr = s.rt;
    bus.in_rs_data = s.rs_d;    bus.in_rt_data = s.rt_d;
    bus.in_imm = s.imm;         bus.in_use_imm = s.use_imm;
    bus.in_dest = s.dest;       bus.in_reg_write = s.rw;  bus.in_mem_read = s.mr;
    bus.alu_result = alu_r;
    bus.mem_fwd_we = s.mem_we;  bus.mem_fwd_addr = s.mem_addr; bus.mem_fwd_data = s.mem_data;
    bus.flush = s.flush;        bus.stall_in = s.stall;

    ld = s.valid && m_valid && m_mr && m_dest != 0 &&
         (m_dest == s.rs || (!s.use_imm && m_dest == s.rt));
`ifdef ALU_ISSUE_FWD_EN
    haz = ld;
`else
    haz = ld || (s.valid && (pending_writer(s.rs, s) || (!s.use_imm && pending_writer(s.rt, s))));
`endif
    e.stall = s.stall || (haz && !s.flush);

    if (s.flush || (!s.stall && (haz || !s.valid))) begin
      m_valid = 1'b0; m_rw = 1'b0; m_mr = 1'b0;
    end else if (!s.stall) begin
      m_opa = src_val(s.rs, s.rs_d, alu_r, s);
      m_opb = s.use_imm ? {{16{s.imm[15]}}, s.imm} : src_val(s.rt, s.rt_d, alu_r, s);
      m_cmd = s.cmd; m_valid = 1'b1; m_dest = s.dest; m_rw = s.rw; m_mr = s.mr;
    end
    e.opa = m_opa; e.opb = m_opb; e.cmd = m_cmd;
    e.valid = m_valid; e.dest = m_dest; e.rw = m_rw; e.mr = m_mr;
    sbq.push_back(e);
  endtask

  function automatic stim_t rand_stim();
    stim_t s;
    s.valid    = ($urandom_range(0, 9) < 8);
    s.cmd      = 3'($urandom_range(0, 7));
    s.rs       = 5'($urandom_range(0, 3));
    s.rt       = 5'($urandom_range(0, 3));
    s.rs_d     = $urandom;
    s.rt_d     = $urandom;
    s.imm      = 16'($urandom);
    s.use_imm  = ($urandom_range(0, 3) == 0);
    s.dest     = 5'($urandom_range(0, 3));
    s.rw       = ($urandom_range(0, 3) != 0);
    s.mr       = ($urandom_range(0, 4) == 0);
    s.mem_we   = ($urandom_range(0, 2) == 0);
    s.mem_addr = 5'($urandom_range(0, 3));
    s.mem_data = $urandom;
    s.flush    = ($urandom_range(0, 15) == 0);
    s.stall    = ($urandom_range(0, 9) == 0);
    return s;
  endfunction

  // Monitor: combinational hold request mid-cycle, registered state after the edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (mon_en && sbq.size() > 0) begin
        e = sbq[0];
        chk("stall_out", {31'd0, bus.stall_out}, {31'd0, e.stall});
        @(posedge clk);
        #1;
        chk("operandA", bus.operandA, e.opa);
        chk("operandB", bus.operandB, e.opb);
        chk("command", {29'd0, bus.command}, {29'd0, e.cmd});
        chk("ex_valid", {31'd0, bus.ex_valid}, {31'd0, e.valid});
        chk("ex_dest", {27'd0, bus.ex_dest}, {27'd0, e.dest});
        chk("ex_reg_write", {31'd0, bus.ex_reg_write}, {31'd0, e.rw});
        chk("ex_mem_read", {31'd0, bus.ex_mem_read}, {31'd0, e.mr});
        void'(sbq.pop_front());
      end
    end
  end

  initial begin
    stim_t s;
    s = '0;
    bus.in_valid = 0; bus.in_command = 0; bus.in_rs_addr = 0; bus.in_rt_addr = 0;
    bus.in_rs_data = 0; bus.in_rt_data = 0; bus.in_imm = 0; bus.in_use_imm = 0;
    bus.in_dest = 0; bus.in_reg_write = 0; bus.in_mem_read = 0; bus.alu_result = 0;
    bus.mem_fwd_we = 0; bus.mem_fwd_addr = 0; bus.mem_fwd_data = 0;
    bus.flush = 0; bus.stall_in = 0;
    model_reset();

    #2 rst_n = 1'b0;
    #1;
    chk("rst_operandA", bus.operandA, 32'h0);
    chk("rst_command", {29'd0, bus.command}, 32'h0);
    chk("rst_ex_valid", {31'd0, bus.ex_valid}, 32'h0);
    bus.stall_in = 1'b1;
    #1 chk("rst_stall_pass", {31'd0, bus.stall_out}, 32'h1);
    bus.stall_in = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    mon_en = 1'b1;

    // EX forward: held ADD 2+3 into $8, then consumer of $8.
    s = '0; s.valid = 1; s.cmd = ADD; s.rs = 1; s.rs_d = 2; s.rt = 2; s.rt_d = 3;
    s.dest = 8; s.rw = 1;
    step(s);
    s = '0; s.valid = 1; s.cmd = ADD; s.rs = 8; s.rs_d = 32'hDEADBEEF; s.dest = 3; s.rw = 1;
    step(s);
`ifdef ALU_ISSUE_FWD_EN
    @(posedge clk); #2 chk("ex_fwd_opA", bus.operandA, 32'h5);
`endif

    // Priority: held result 7 into $9 vs MEM $9=3; then held dest moves to $4.
    s = '0; s.valid = 1; s.cmd = ADD; s.rs = 1; s.rs_d = 7; s.dest = 9; s.rw = 1;
    step(s);
    s = '0; s.valid = 1; s.cmd = ADD; s.rt = 9; s.rt_d = 32'hAAAA; s.dest = 4; s.rw = 1;
    s.mem_we = 1; s.mem_addr = 9; s.mem_data = 3;
    step(s);
    s = '0; s.valid = 1; s.cmd = ADD; s.rt = 9; s.rt_d = 32'hAAAA; s.dest = 5; s.rw = 1;
    s.mem_we = 1; s.mem_addr = 9; s.mem_data = 3;
    step(s);

    // $0 never forwards.
    s = '0; s.valid = 1; s.cmd = ADD; s.rs = 1; s.rs_d = 32'h55; s.dest = 0; s.rw = 1;
    step(s);
    s = '0; s.valid = 1; s.cmd = OR; s.rs = 0; s.rs_d = 0; s.dest = 6; s.rw = 1;
    step(s);

    // Load-use on rt, then the replayed consumer picks the load data from MEM.
    s = '0; s.valid = 1; s.cmd = ADD; s.dest = 10; s.rw = 1; s.mr = 1;
    step(s);
    s = '0; s.valid = 1; s.cmd = ADD; s.rt = 10; s.rt_d = 32'hBAD; s.dest = 11; s.rw = 1;
    step(s);
    s.mem_we = 1; s.mem_addr = 10; s.mem_data = 32'h1234;
    step(s);

    // Sign-extended immediate, then flush beats stall_in.
    s = '0; s.valid = 1; s.cmd = ADD; s.use_imm = 1; s.imm = 16'hFFFC; s.rt = 10; s.dest = 12;
    s.rw = 1;
    step(s);
    @(posedge clk); #2 chk("imm_opB", bus.operandB, 32'hFFFFFFFC);
    s = '0; s.valid = 1; s.dest = 13; s.rw = 1; s.mr = 1; s.flush = 1; s.stall = 1;
    step(s);
    @(posedge clk); #2;
    chk("flush_ex_valid", {31'd0, bus.ex_valid}, 32'h0);
    chk("flush_ex_rw", {31'd0, bus.ex_reg_write}, 32'h0);

    // Mid-cycle asynchronous reset right after a valid ADD was captured.
    s = '0; s.valid = 1; s.cmd = ADD; s.rs = 1; s.rs_d = 32'h11; s.dest = 7; s.rw = 1;
    step(s);
    @(posedge clk); #3;
    mon_en = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_opA", bus.operandA, 32'h0);
    chk("mid_rst_opB", bus.operandB, 32'h0);
    chk("mid_rst_ex_valid", {31'd0, bus.ex_valid}, 32'h0);
    chk("mid_rst_ex_dest", {27'd0, bus.ex_dest}, 32'h0);
    chk("mid_rst_stall_out", {31'd0, bus.stall_out}, 32'h0);
    model_reset();
    sbq.delete();
    @(negedge clk);
    rst_n = 1'b1;
    mon_en = 1'b1;

    for (int i = 0; i < 400; i++) step(rand_stim());

    s = '0;
    step(s);
    repeat (5) @(posedge clk);
    chk("scoreboard_drained", sbq.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_issue_stage.md
# alu_issue_stage

ID/EX pipeline register that sits directly upstream of the ALU in the MIPS-subset core. It captures decoded instructions and resolves RAW hazards by forwarding the ALU's own result and the MEM-stage result into the operand paths. It detects load-use hazards and inserts bubbles, then presents registered `operandA`, `operandB` and `command` to the ALU together with the destination bookkeeping that the downstream stages need.

## Interface
- `WIDTH`, 32: datapath width; must match the ALU's `width`.
- `clk` input 1: the single clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous reset, active-low.
- `in_valid` input 1: the decode stage presents an instruction.
- `in_command` input 3: ALU command, using the shared encoding.
- `in_rs_addr`, `in_rt_addr` input 5 each: source register numbers.
- `in_rs_data`, `in_rt_data` input WIDTH each: register-file read data.
- `in_imm` input 16: immediate; sign-extended to WIDTH.
- `in_use_imm` input 1: operandB takes the immediate instead of rt.
- `in_dest` input 5, `in_reg_write` input 1, `in_mem_read` input 1: destination register, writes-register flag, and is-load flag.
- `alu_result` input WIDTH: ALU output for the instruction this stage currently holds.
- `mem_fwd_we` input 1, `mem_fwd_addr` input 5, `mem_fwd_data` input WIDTH: MEM-stage writeback candidate.
- `flush` input 1: kill the instruction being captured.
- `stall_in` input 1: downstream hold.
- `stall_out` output 1: hold request to fetch/decode; combinational.
- `operandA`, `operandB` output WIDTH: registered ALU operands.
- `command` output 3: registered ALU command.
- `ex_valid`, `ex_dest` (5), `ex_reg_write`, `ex_mem_read` outputs: registered bookkeeping for the held instruction.

## Operation
- **Forwarding for each source** (rs → A; rt → B unless `in_use_imm`):
  - EX hit: `ex_valid & ex_reg_write & ~ex_mem_read & ex_dest==addr` selects `alu_result`.
  - Otherwise MEM hit: `mem_fwd_we & mem_fwd_addr==addr` selects `mem_fwd_data`.
  - Otherwise the register-file data is used.
  - EX has priority over MEM. Address 0 never matches, so `$0` always reads `in_*_data`.
- **Immediate:** when `in_use_imm`=1, operandB = `{{(WIDTH-16){in_imm[15]}}, in_imm}`.
- **load_use** = `in_valid & ex_valid & ex_mem_read & ex_dest!=0 & (ex_dest==in_rs_addr | (~in_use_imm & ex_dest==in_rt_addr))`.
- **Next-state priority** (highest first):
  1. `flush`: capture a bubble (`ex_valid`, `ex_reg_write`, `ex_mem_read` = 0; operands and command unchanged).
  2. `stall_in`: hold all registers.
  3. `load_use`: capture a bubble.
  4. Otherwise capture the forwarded inputs. When `in_valid`=0, a bubble is captured.
- **stall_out** = `stall_in | (load_use & ~flush)`.
- A bubble never asserts `ex_reg_write` or `ex_mem_read`.

## Timing
- One-cycle latency: inputs sampled at edge N appear on the outputs after edge N.
- `alu_result` forwarding is same-cycle combinational, ALU → mux → register. This is the critical path.
- A load-use stall lasts exactly one cycle. On the following cycle the load sits in MEM and its data arrives via `mem_fwd_*`.
- Reset (asserted at any time, including mid-stall) clears every register immediately:
  - `operandA` = `operandB` = 0, `command` = ADD (3'b000).
  - `ex_valid` = `ex_reg_write` = `ex_mem_read` = 0, `ex_dest` = 0.
  - `stall_out` = `stall_in`.
- Simultaneous `flush` and `stall_in`: flush wins and captures a bubble.

## Configuration
- `ALU_ISSUE_FWD_EN` defined: forwarding as described above.
- Undefined: no forwarding muxes; `alu_result` and `mem_fwd_data` are unused.
  - The hazard term widens to any nonzero source match against the held instruction (`ex_valid & ex_reg_write`) or against `mem_fwd_we & mem_fwd_addr`.
  - On such a match the stage stalls and inserts bubbles until no match remains.

## Structure
- Shared package `alu_pkg`:
  - command localparams ADD, SUB, XOR, SLT, AND, NAND, NOR, OR (3'b000–3'b111);
  - `REG_ADDR_W` = 5 and `REG_ZERO` = 0.
  - The ALU imports the same package.
- One sub-module, `fwd_mux`, per source operand: address, register-file data, EX and MEM candidates → selected data. Instantiated twice.

## Test plan
- **Reset:** drive a valid ADD, then pull `rst_n` low mid-cycle → all outputs 0 immediately, `ex_valid`=0, `stall_out`=0.
- **EX forward:** held ADD with `ex_dest`=8 and `alu_result`=0x00000005; incoming rs=8 with `in_rs_data`=0xDEADBEEF → next-cycle `operandA`=0x00000005.
- **Priority:** EX dest 9 with result 7 and MEM fwd addr 9 with data 3; incoming rt=9 → `operandB`=7. With EX dest 4 instead → `operandB`=3.
- **$0:** EX dest 0 with `reg_write` and `alu_result`=0x55; rs=0 with `in_rs_data`=0 → `operandA`=0.
- **Load-use:** held load with dest 10; incoming rt=10 → `stall_out`=1 for one cycle and a bubble (`ex_valid`=0). Next cycle, `mem_fwd` addr 10 with data 0x1234 → `operandB`=0x1234.
- **Immediate and flush:** `in_use_imm` with imm 0xFFFC → `operandB`=0xFFFFFFFC. Then `flush` together with `stall_in` → `ex_valid`=0, `ex_reg_write`=0.
